// File: rtl/exec_regfile_stage_pkg.sv
// Shared constants for the execute/writeback stage: datapath sizes and ALU op encodings.
package exec_regfile_stage_pkg;
  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_AW    = $clog2(REG_COUNT);
  localparam int OP_W      = 5;

  localparam logic [OP_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [OP_W-1:0] ALU_XOR  = 5'd2;
  localparam logic [OP_W-1:0] ALU_OR   = 5'd3;
  localparam logic [OP_W-1:0] ALU_AND  = 5'd4;
  localparam logic [OP_W-1:0] ALU_SLL  = 5'd5;
  localparam logic [OP_W-1:0] ALU_SRL  = 5'd6;
  localparam logic [OP_W-1:0] ALU_SRA  = 5'd7;
  localparam logic [OP_W-1:0] ALU_SLT  = 5'd8;
  localparam logic [OP_W-1:0] ALU_SLTU = 5'd9;
  localparam logic [OP_W-1:0] ALU_NOP  = 5'd31;
endpackage

// File: rtl/exec_regfile_stage_alu.sv
// Combinational RV32I R-type ALU; unknown ops and NOP produce zero.
module rv32i_alu
  import exec_regfile_stage_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_XOR:  y = a ^ b;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/exec_regfile_stage.sv
// Two-stage execute/writeback: operand capture with forwarding, then ALU + register file writeback.
module exec_regfile_stage
  import exec_regfile_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic [OP_W-1:0]   alu_control,
  input  logic              dbg_we,
  input  logic [REG_AW-1:0] dbg_waddr,
  input  logic [XLEN-1:0]   dbg_wdata,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [XLEN-1:0]   dbg_rdata,
  output logic [XLEN-1:0]   result,
  output logic [REG_AW-1:0] result_rd,
  output logic              result_valid,
  output logic              result_nop
);
  logic [XLEN-1:0]   rf_q [REG_COUNT];

  logic              s1_valid_q;
  logic [REG_AW-1:0] s1_rd_q;
  logic [OP_W-1:0]   s1_op_q;
  logic [XLEN-1:0]   s1_a_q, s1_a_d;
  logic [XLEN-1:0]   s1_b_q, s1_b_d;

  logic [XLEN-1:0]   result_q;
  logic [REG_AW-1:0] result_rd_q;
  logic              result_valid_q;
  logic              result_nop_q;

  logic [XLEN-1:0]   alu_out;
  logic              wb_en;

  rv32i_alu u_alu (
    .op (s1_op_q),
    .a  (s1_a_q),
    .b  (s1_b_q),
    .y  (alu_out)
  );

  // The same condition gates writeback and forwarding, so NOPs and x0 never forward.
  assign wb_en = s1_valid_q && (s1_rd_q != '0) && (s1_op_q != ALU_NOP);

  always_comb begin
    s1_a_d = rf_q[rs1];
    if (rs1 == '0)                 s1_a_d = '0;
    else if (wb_en && s1_rd_q == rs1) s1_a_d = alu_out;
    s1_b_d = rf_q[rs2];
    if (rs2 == '0)                 s1_b_d = '0;
    else if (wb_en && s1_rd_q == rs2) s1_b_d = alu_out;
  end

  // Pipeline writeback is issued after the debug write so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else begin
      if (dbg_we && dbg_waddr != '0) rf_q[dbg_waddr] <= dbg_wdata;
      if (wb_en)                     rf_q[s1_rd_q]   <= alu_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q     <= 1'b0;
      s1_rd_q        <= '0;
      s1_op_q        <= ALU_NOP;
      s1_a_q         <= '0;
      s1_b_q         <= '0;
      result_q       <= '0;
      result_rd_q    <= '0;
      result_valid_q <= 1'b0;
      result_nop_q   <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_rd_q <= rd;
        s1_op_q <= alu_control;
        s1_a_q  <= s1_a_d;
        s1_b_q  <= s1_b_d;
      end
      result_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q     <= alu_out;
        result_rd_q  <= s1_rd_q;
        result_nop_q <= (s1_op_q == ALU_NOP);
      end
    end
  end

  assign dbg_rdata    = (dbg_raddr == '0) ? '0 : rf_q[dbg_raddr];
  assign result       = result_q;
  assign result_rd    = result_rd_q;
  assign result_valid = result_valid_q;
  assign result_nop   = result_nop_q;
endmodule
